// File: rtl/mips_alu_pkg.sv
// Shared definitions for the EX-stage ALU control and the iterative mul/div unit.
// Contents: ALUOp encodings, funct codes, 3-bit ALU control codes, the
// mul/div FSM state type and a helper that classifies mul/div/move functs.
package mips_alu_pkg;

  // ALUOp from main control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // R-type funct codes
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  // ALU control codes
  localparam logic [2:0] CTRL_AND = 3'b000;
  localparam logic [2:0] CTRL_OR  = 3'b001;
  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_SUB = 3'b110;
  localparam logic [2:0] CTRL_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    SIGN = 2'd3
  } md_state_e;

  // True for the eight funct codes owned by the mul/div unit.
  function automatic logic is_md_funct(input logic [5:0] f);
    return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU) ||
           (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath with its sequencing FSM.
// Multiply: shift-add, one multiplier bit per cycle. Divide: restoring, one
// quotient bit per cycle. Both work on operand magnitudes; the SIGN state
// applies the sign correction and presents the result for one cycle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           accept a MULT*/DIV* this edge (only honoured in IDLE)
//   start_div       1 = divide, 0 = multiply
//   start_signed    1 = signed form
//   a, b            rs / rt operands
//   state           current FSM state (debug visibility)
//   done            high during SIGN; hi_res/lo_res valid
//   hi_res, lo_res  corrected result halves
module muldiv_iter
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_div,
  input  logic             start_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output md_state_e        state,
  output logic             done,
  output logic [WIDTH-1:0] hi_res,
  output logic [WIDTH-1:0] lo_res
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  md_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  // acc_q: product high half / partial remainder
  // shf_q: multiplier shifting out + product low half / dividend shifting out + quotient
  // opb_q: multiplicand / divisor magnitude
  logic [WIDTH-1:0] acc_q, shf_q, opb_q;
  logic neg_lo_q, neg_hi_q, dz_q, div_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ok;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_neg = start_signed & a[WIDTH-1];
  assign b_neg = start_signed & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // One shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift {acc, shf} right by one.
  assign mul_sum = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opb_q} : '0);

  // One restoring step: bring in the next dividend bit and subtract if it fits.
  // When it fits the difference is below the divisor, so WIDTH bits hold it.
  assign div_trial = {acc_q, shf_q[WIDTH-1]};
  assign div_ok    = div_trial >= {1'b0, opb_q};
  assign div_rem   = div_trial[WIDTH-1:0] - opb_q;

  assign prod     = {acc_q, shf_q};
  assign prod_fix = neg_lo_q ? -prod : prod;

  // Result correction. Divide-by-zero leaves the restoring datapath with an
  // all-ones quotient and the dividend magnitude as remainder; only the
  // quotient must bypass the sign fix, the remainder fix restores src_a.
  always_comb begin
    hi_res = prod_fix[2*WIDTH-1:WIDTH];
    lo_res = prod_fix[WIDTH-1:0];
    if (div_q) begin
      hi_res = neg_hi_q ? -acc_q : acc_q;
      lo_res = dz_q ? '1 : (neg_lo_q ? -shf_q : shf_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = start_div ? DIV : MUL;
      MUL,
      DIV:     if (cnt_q == LAST) state_d = SIGN;
      SIGN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      shf_q    <= '0;
      opb_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      div_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            div_q    <= start_div;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            dz_q     <= (b == '0);
            shf_q    <= start_div ? a_mag : b_mag;
            opb_q    <= start_div ? b_mag : a_mag;
          end
        end
        MUL: begin
          acc_q <= mul_sum[WIDTH:1];
          shf_q <= {mul_sum[0], shf_q[WIDTH-1:1]};
          if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
        end
        DIV: begin
          acc_q <= div_ok ? div_rem : div_trial[WIDTH-1:0];
          shf_q <= {shf_q[WIDTH-2:0], div_ok};
          if (cnt_q != LAST) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign state = state_q;
  assign done  = (state_q == SIGN);

endmodule

// File: rtl/alu_control_muldiv.sv
// EX-stage ALU control with iterative multiply/divide and HI/LO registers.
// Decodes ALUOp/funct into the ALU control code, accepts mul/div/move ops when
// the unit is idle, stalls the pipeline while it is busy, and owns HI/LO.
// Handshake: an md op is presented with ex_valid; it is taken at the edge
// where md_stall is low, otherwise the held pipeline re-presents it.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ex_valid, alu_op,     EX instruction valid, ALUOp, funct field
//   funct
//   src_a, src_b          rs / rt operands
//   alu_control, illegal  decoded ALU op code, unknown-combination flag
//   md_stall, md_busy     pipeline freeze request, iteration in progress
//   md_done               HI/LO written at the end of this cycle
//   md_result             HI (MFHI) / LO (MFLO) / 0
//   hi, lo                architectural HI/LO
module alu_control_muldiv
  import mips_alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_valid,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  output logic [CTRL_W-1:0]  alu_control,
  output logic               illegal,
  output logic               md_stall,
  output logic               md_busy,
  output logic               md_done,
  output logic [WIDTH-1:0]   md_result,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  md_state_e        md_state;
  logic             md_funct;
  logic             md_op;
  logic             accept;
  logic             start;
  logic             iter_done;
  logic [WIDTH-1:0] hi_res, lo_res;
  logic [WIDTH-1:0] hi_q, lo_q;

  assign md_funct = is_md_funct(6'(funct));

  always_comb begin
    alu_control = CTRL_W'(CTRL_AND);
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = CTRL_W'(CTRL_ADD);
      ALUOP_SUB: alu_control = CTRL_W'(CTRL_SUB);
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_W'(F_ADD): alu_control = CTRL_W'(CTRL_ADD);
          FUNCT_W'(F_SUB): alu_control = CTRL_W'(CTRL_SUB);
          FUNCT_W'(F_AND): alu_control = CTRL_W'(CTRL_AND);
          FUNCT_W'(F_OR):  alu_control = CTRL_W'(CTRL_OR);
          FUNCT_W'(F_SLT): alu_control = CTRL_W'(CTRL_SLT);
          default: begin
            if (md_funct) alu_control = CTRL_W'(CTRL_ADD);
            else          illegal     = 1'b1;
          end
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

  assign md_op   = ex_valid & (alu_op == ALUOP_FUNCT) & md_funct;
  assign md_busy = (md_state != IDLE);
  assign md_stall = md_op & md_busy;
  assign accept  = md_op & ~md_busy;
  // MULT/MULTU/DIV/DIVU share the 0110xx pattern: bit1 selects divide, bit0 unsigned.
  assign start   = accept & (funct[FUNCT_W-1:2] == (FUNCT_W-2)'(4'b0110));

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk          (clk),
    .rst          (reset),
    .start        (start),
    .start_div    (funct[1]),
    .start_signed (~funct[0]),
    .a            (src_a),
    .b            (src_b),
    .state        (md_state),
    .done         (iter_done),
    .hi_res       (hi_res),
    .lo_res       (lo_res)
  );

  // An accept and a completion never coincide: accept needs IDLE, done needs SIGN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (iter_done) begin
      hi_q <= hi_res;
      lo_q <= lo_res;
    end else if (accept && funct == FUNCT_W'(F_MTHI)) begin
      hi_q <= src_a;
    end else if (accept && funct == FUNCT_W'(F_MTLO)) begin
      lo_q <= src_a;
    end
  end

  always_comb begin
    md_result = '0;
    if (md_op && funct == FUNCT_W'(F_MFHI)) md_result = hi_q;
    if (md_op && funct == FUNCT_W'(F_MFLO)) md_result = lo_q;
  end

  assign md_done = iter_done;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_alu_control_muldiv.sv
module tb_alu_control_muldiv;
  import mips_alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         ex_valid;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] src_a, src_b;
  logic [2:0]   alu_control;
  logic         illegal, md_stall, md_busy, md_done;
  logic [W-1:0] md_result, hi, lo;

  int n_tests = 0;
  int n_fail  = 0;

  alu_control_muldiv #(.WIDTH(W), .FUNCT_W(6), .CTRL_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .alu_op      (alu_op),
    .funct       (funct),
    .src_a       (src_a),
    .src_b       (src_b),
    .alu_control (alu_control),
    .illegal     (illegal),
    .md_stall    (md_stall),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_result   (md_result),
    .hi          (hi),
    .lo          (lo)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference models ----------------
  typedef struct {
    logic [1:0] op;
    logic [5:0] f;
    logic [2:0] ctrl;
    logic       ill;
  } dec_vec_t;

  function automatic dec_vec_t ref_decode(input logic [1:0] op, input logic [5:0] f);
    dec_vec_t v;
    v.op = op; v.f = f; v.ctrl = 3'b000; v.ill = 1'b1;
    if (op == 2'b00) begin v.ctrl = 3'b010; v.ill = 1'b0; end
    else if (op == 2'b01) begin v.ctrl = 3'b110; v.ill = 1'b0; end
    else if (op == 2'b10) begin
      v.ill = 1'b0;
      if      (f == 6'b100000) v.ctrl = 3'b010;
      else if (f == 6'b100010) v.ctrl = 3'b110;
      else if (f == 6'b100100) v.ctrl = 3'b000;
      else if (f == 6'b100101) v.ctrl = 3'b001;
      else if (f == 6'b101010) v.ctrl = 3'b111;
      else if (f inside {6'b011000, 6'b011001, 6'b011010, 6'b011011,
                         6'b010000, 6'b010001, 6'b010010, 6'b010011}) v.ctrl = 3'b010;
      else v.ill = 1'b1;
    end
    return v;
  endfunction

  // HI/LO from plain 64-bit arithmetic.
  task automatic ref_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] rhi, output logic [W-1:0] rlo);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    rhi = '0; rlo = '0;
    case (f)
      F_MULT:  begin sp = sa * sb; rhi = sp[63:32]; rlo = sp[31:0]; end
      F_MULTU: begin up = ua * ub; rhi = up[63:32]; rlo = up[31:0]; end
      F_DIV: begin
        if (b == 0) begin rhi = a; rlo = '1; end
        else begin sq = sa / sb; sr = sa % sb; rhi = sr[31:0]; rlo = sq[31:0]; end
      end
      F_DIVU: begin
        if (b == 0) begin rhi = a; rlo = '1; end
        else begin uq = ua / ub; ur = ua % ub; rhi = ur[31:0]; rlo = uq[31:0]; end
      end
      default: ;
    endcase
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Presents the op for one edge, then
  // watches the iteration with a cycle budget.
  task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int busy_cycles, output int done_at, output bit seen);
    ex_valid = 1'b1; alu_op = 2'b10; funct = f; src_a = a; src_b = b;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    busy_cycles = 0; done_at = -1; seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (md_busy) busy_cycles++;
      if (md_done) begin seen = 1'b1; done_at = busy_cycles; end
    end
    @(posedge clk); #1;
  endtask

  task automatic move_op(input logic [5:0] f, input logic [W-1:0] a);
    ex_valid = 1'b1; alu_op = 2'b10; funct = f; src_a = a; src_b = '0;
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic md_checked(input string tag, input logic [5:0] f,
                            input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] eh, el;
    int bc, da;
    bit sn;
    ref_md(f, a, b, eh, el);
    run_md(f, a, b, bc, da, sn);
    check({tag, "_done_seen"}, 64'(sn), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
  endtask

  // ---------------- stimulus ----------------
  dec_vec_t dec_tab[$];
  dec_vec_t rv;
  logic [W-1:0] eh, el, hold_hi, hold_lo;
  int bc, da;
  bit sn, stall_bad, idle_seen, late_done;
  logic [5:0] md_list[4];
  logic [5:0] rf;
  logic [W-1:0] ra, rb;

  initial begin
    reset = 1'b1; ex_valid = 1'b0; alu_op = 2'b00; funct = '0; src_a = '0; src_b = '0;
    md_list[0] = F_MULT; md_list[1] = F_MULTU; md_list[2] = F_DIV; md_list[3] = F_DIVU;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_during", 64'(md_busy), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(md_busy), 64'd0);
    check("rst_done", 64'(md_done), 64'd0);
    check("rst_stall", 64'(md_stall), 64'd0);

    // ---- decode table (expected values written out by hand) ----
    dec_tab.push_back('{2'b00, 6'b000000, 3'b010, 1'b0});
    dec_tab.push_back('{2'b01, 6'b111111, 3'b110, 1'b0});
    dec_tab.push_back('{2'b10, 6'b100000, 3'b010, 1'b0});
    dec_tab.push_back('{2'b10, 6'b100010, 3'b110, 1'b0});
    dec_tab.push_back('{2'b10, 6'b100100, 3'b000, 1'b0});
    dec_tab.push_back('{2'b10, 6'b100101, 3'b001, 1'b0});
    dec_tab.push_back('{2'b10, 6'b101010, 3'b111, 1'b0});
    dec_tab.push_back('{2'b10, 6'b011000, 3'b010, 1'b0});
    dec_tab.push_back('{2'b10, 6'b011011, 3'b010, 1'b0});
    dec_tab.push_back('{2'b10, 6'b010011, 3'b010, 1'b0});
    dec_tab.push_back('{2'b10, 6'b000111, 3'b000, 1'b1});
    dec_tab.push_back('{2'b10, 6'b010100, 3'b000, 1'b1});
    dec_tab.push_back('{2'b11, 6'b100000, 3'b000, 1'b1});
    foreach (dec_tab[i]) begin
      alu_op = dec_tab[i].op; funct = dec_tab[i].f;
      #1;
      check($sformatf("dec_ctrl_%0d", i), 64'(alu_control), 64'(dec_tab[i].ctrl));
      check($sformatf("dec_ill_%0d", i), 64'(illegal), 64'(dec_tab[i].ill));
    end

    // ---- random decode against the rule model ----
    for (int i = 0; i < 40; i++) begin
      alu_op = 2'($urandom_range(0, 3));
      funct  = (i % 2 == 0) ? 6'($urandom_range(16, 43)) : 6'($urandom);
      rv = ref_decode(alu_op, funct);
      #1;
      check("rnd_dec_ctrl", 64'(alu_control), 64'(rv.ctrl));
      check("rnd_dec_ill", 64'(illegal), 64'(rv.ill));
    end
    @(posedge clk); #1;

    // ---- MULT latency and result ----
    ref_md(F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, eh, el);
    run_md(F_MULT, 32'hFFFF_FFFD, 32'h0000_0007, bc, da, sn);
    check("mult_busy_cycles", 64'(bc), 64'd33);
    check("mult_done_at", 64'(da), 64'd33);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFEB);
    check("mult_model_hi", 64'(hi), 64'(eh));
    check("mult_idle_after", 64'(md_busy), 64'd0);

    // Directed values from the published examples
    run_md(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc, da, sn);
    check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_lo", 64'(lo), 64'h0000_0001);
    run_md(F_DIVU, 32'd100, 32'd7, bc, da, sn);
    check("divu_busy_cycles", 64'(bc), 64'd33);
    check("divu_lo", 64'(lo), 64'h0000_000E);
    check("divu_hi", 64'(hi), 64'h0000_0002);
    run_md(F_DIV, 32'hFFFF_FFF9, 32'h0000_0002, bc, da, sn);
    check("div_neg_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_neg_hi", 64'(hi), 64'hFFFF_FFFF);
    run_md(F_DIV, 32'h0000_0005, 32'h0, bc, da, sn);
    check("div0_hi", 64'(hi), 64'h0000_0005);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    check("div0_latency", 64'(da), 64'd33);
    run_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc, da, sn);
    check("divmin_lo", 64'(lo), 64'h8000_0000);
    check("divmin_hi", 64'(hi), 64'h0000_0000);
    md_checked("div0_negdividend", F_DIV, 32'hFFFF_FF00, 32'h0);
    md_checked("divu0", F_DIVU, 32'h8765_4321, 32'h0);

    // ---- moves ----
    move_op(F_MTHI, 32'hA5A5_0001);
    move_op(F_MTLO, 32'h5A5A_0002);
    check("mthi", 64'(hi), 64'hA5A5_0001);
    check("mtlo", 64'(lo), 64'h5A5A_0002);
    ex_valid = 1'b1; alu_op = 2'b10; funct = F_MFHI; #1;
    check("mfhi_result", 64'(md_result), 64'hA5A5_0001);
    funct = F_MFLO; #1;
    check("mflo_result", 64'(md_result), 64'h5A5A_0002);
    funct = F_ADD; #1;
    check("nonmd_result_zero", 64'(md_result), 64'd0);
    ex_valid = 1'b0;
    @(posedge clk); #1;

    // ---- randomized mul/div against the arithmetic model ----
    for (int i = 0; i < 40; i++) begin
      rf = md_list[$urandom_range(0, 3)];
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: rb = $urandom;
      endcase
      ref_md(rf, ra, rb, eh, el);
      run_md(rf, ra, rb, bc, da, sn);
      check($sformatf("rnd_md_%0d_done", i), 64'(sn), 64'd1);
      check($sformatf("rnd_md_%0d_hi f=%b a=%h b=%h", i, rf, ra, rb), 64'(hi), 64'(eh));
      check($sformatf("rnd_md_%0d_lo f=%b a=%h b=%h", i, rf, ra, rb), 64'(lo), 64'(el));
      ex_valid = 1'b1; alu_op = 2'b10; funct = F_MFHI; #1;
      check("rnd_mfhi", 64'(md_result), 64'(eh));
      ex_valid = 1'b0;
      @(posedge clk); #1;
    end

    // ---- stall while busy, MFLO held until the result lands ----
    ref_md(F_MULT, 32'h0000_1234, 32'hFFFF_FF00, eh, el);
    ex_valid = 1'b1; alu_op = 2'b10; funct = F_MULT; src_a = 32'h0000_1234; src_b = 32'hFFFF_FF00;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(posedge clk); #1;
    ex_valid = 1'b1; funct = F_MULT; src_a = 32'h0000_DEAD; src_b = 32'h0000_BEEF;
    #1;
    check("busy_mult_stalled", 64'(md_stall), 64'd1);
    @(posedge clk); #1;
    ex_valid = 1'b1; funct = F_MFLO; src_a = '0; src_b = '0;
    stall_bad = 1'b0; idle_seen = 1'b0;
    for (int i = 0; i < 60 && !idle_seen; i++) begin
      @(negedge clk);
      if (md_busy) begin
        if (!md_stall) stall_bad = 1'b1;
      end else begin
        idle_seen = 1'b1;
      end
    end
    check("mflo_stall_held", 64'(stall_bad), 64'd0);
    check("mflo_idle_reached", 64'(idle_seen), 64'd1);
    check("mflo_stall_released", 64'(md_stall), 64'd0);
    check("mflo_new_lo", 64'(md_result), 64'(el));
    @(posedge clk); #1;
    ex_valid = 1'b0;
    check("second_mult_ignored_hi", 64'(hi), 64'(eh));
    check("second_mult_ignored_lo", 64'(lo), 64'(el));
    check("second_mult_not_started", 64'(md_busy), 64'd0);

    // ---- reset mid-iteration ----
    hold_hi = hi; hold_lo = lo;
    ex_valid = 1'b1; alu_op = 2'b10; funct = F_MULT; src_a = 32'h1234_5678; src_b = 32'h0000_0003;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_reset", 64'(md_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("midrst_busy", 64'(md_busy), 64'd0);
    check("midrst_done", 64'(md_done), 64'd0);
    check("midrst_hi", 64'(hi), 64'd0);
    check("midrst_lo", 64'(lo), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    move_op(F_MTHI, 32'h1234_5678);
    check("post_rst_mthi", 64'(hi), 64'h1234_5678);
    check("post_rst_lo", 64'(lo), 64'd0);
    late_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (md_done || md_busy) late_done = 1'b1;
    end
    check("discarded_result_stays_gone", 64'(late_done), 64'd0);
    check("post_rst_hi_kept", 64'(hi), 64'h1234_5678);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "timeout");
  end

endmodule
